// File: rtl/piso_shift_register.sv
// piso_shift_register
//   Parallel-in, serial-out shift register with a valid/ready load handshake.
//   A WIDTH-bit word is accepted when load_valid && load_ready, then sent one
//   bit per clock on serial_out. A new word may be accepted during the last
//   bit cycle of the current word, so words stream back-to-back with no gap.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   load_valid    parallel_in holds a word to send
//   load_ready    a word can be accepted this cycle (combinational)
//   parallel_in   word to serialize, sampled only on an accept edge
//   serial_out    current serial bit
//   serial_valid  serial_out carries a valid data bit
//   last_bit      high during the final bit of a word
module piso_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] shifted;
  logic             head_bit;
  logic             accept;

  // Bit order only changes which end of the register is the output end and
  // which way the register moves; zeros are shifted in behind the data.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted  = {shreg[WIDTH-2:0], 1'b0};
      assign head_bit = shreg[WIDTH-1];
    end else begin : g_lsb
      assign shifted  = {1'b0, shreg[WIDTH-1:1]};
      assign head_bit = shreg[0];
    end
  endgenerate

  assign accept = load_valid && load_ready;

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    count_next = count;
    load_ready = rst_n && ((state == IDLE) || (state == SHIFT && count == '0));

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          shreg_next = parallel_in;
          count_next = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (count != '0) begin
          shreg_next = shifted;
          count_next = count - CW'(1);
        end else if (accept) begin
          // Reload in the last bit cycle: the next word starts with no gap.
          shreg_next = parallel_in;
          count_next = CW'(WIDTH - 1);
        end else begin
          state_next = IDLE;
          shreg_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        shreg_next = '0;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      count <= count_next;
    end
  end

  // Outputs are decoded from registered state only, so they are glitch-free
  // with respect to the load inputs.
  assign serial_valid = (state == SHIFT);
  assign serial_out   = (state == SHIFT) && head_bit;
  assign last_bit     = (state == SHIFT) && (count == '0);

endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register
//   Two lanes: lane 0 is MSB-first, lane 1 is LSB-first, both WIDTH = 8.
//   Each lane keeps its own model of the handshake; accepted words are
//   expanded into send-order bits and pushed to a queue, and every valid
//   serial bit pops and compares one entry.
module tb_piso_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   load_valid;
  logic [1:0]   load_ready;
  logic [W-1:0] parallel_in [2];
  logic [1:0]   serial_out;
  logic [1:0]   serial_valid;
  logic [1:0]   last_bit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam bit MSB = (gi == 0);

      piso_shift_register #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid[gi]),
        .load_ready   (load_ready[gi]),
        .parallel_in  (parallel_in[gi]),
        .serial_out   (serial_out[gi]),
        .serial_valid (serial_valid[gi]),
        .last_bit     (last_bit[gi])
      );

      int          m_state = 0;   // 0 = idle, 1 = shifting
      int          m_count = 0;
      bit          exp_q[$];
      logic [31:0] stream = '0;   // received bits, newest in bit 0
      int          nbits = 0;
      int          nlast = 0;
      logic [W-1:0] sipo = '0;    // serial-in/parallel-out receiver

      // Reference model of the handshake, stepped at each rising edge.
      always @(posedge clk) begin
        bit rdy;
        if (serial_valid[gi]) sipo = {sipo[W-2:0], serial_out[gi]};
        if (!rst_n) begin
          m_state = 0;
          m_count = 0;
          exp_q.delete();
        end else begin
          rdy = (m_state == 0) || (m_count == 0);
          if (load_valid[gi] && rdy) begin
            for (int i = 0; i < W; i++)
              exp_q.push_back(MSB ? parallel_in[gi][W-1-i] : parallel_in[gi][i]);
            m_state = 1;
            m_count = W - 1;
            $display("lane %0d: accepted word %02h", gi, parallel_in[gi]);
          end else if (m_state == 1 && m_count > 0) begin
            m_count--;
          end else begin
            m_state = 0;
          end
        end
      end

      always @(negedge clk) begin
        bit e;
        check($sformatf("lane%0d ready", gi), 32'(load_ready[gi]),
              32'(rst_n && (m_state == 0 || m_count == 0)));
        check($sformatf("lane%0d valid", gi), 32'(serial_valid[gi]), 32'(m_state == 1));
        check($sformatf("lane%0d last", gi), 32'(last_bit[gi]),
              32'(m_state == 1 && m_count == 0));
        if (last_bit[gi]) nlast++;
        if (m_state == 1) begin
          if (exp_q.size() == 0) begin
            check($sformatf("lane%0d queue_empty", gi), 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check($sformatf("lane%0d bit", gi), 32'(serial_out[gi]), 32'(e));
          end
          stream = {stream[30:0], serial_out[gi]};
          nbits++;
        end else begin
          check($sformatf("lane%0d idle_out", gi), 32'(serial_out[gi]), 32'(0));
        end
      end
    end
  endgenerate

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int b0, l0, b1;
    bit seen;
    rst_n          = 1'b0;
    load_valid     = 2'b00;
    parallel_in[0] = '0;
    parallel_in[1] = '0;
    tick(2);
    check("reset valid", 32'(serial_valid), 32'(0));
    check("reset out", 32'(serial_out), 32'(0));
    check("reset last", 32'(last_bit), 32'(0));
    check("reset ready", 32'(load_ready), 32'(0));
    rst_n = 1'b1;
    #1;
    check("ready after reset", 32'(load_ready), 32'(2'b11));

    // Single word 8'hA5, MSB first.
    b0 = g_lane[0].nbits; l0 = g_lane[0].nlast;
    parallel_in[0] = 8'hA5; load_valid[0] = 1'b1;
    tick(1);
    load_valid[0] = 1'b0;
    tick(12);
    check("a5 stream", g_lane[0].stream[7:0], 32'hA5);
    check("a5 nbits", g_lane[0].nbits - b0, 8);
    check("a5 nlast", g_lane[0].nlast - l0, 1);

    // Back-to-back 8'hA5 then 8'h3C with load_valid held.
    b0 = g_lane[0].nbits; l0 = g_lane[0].nlast;
    parallel_in[0] = 8'hA5; load_valid[0] = 1'b1;
    tick(1);
    parallel_in[0] = 8'h3C;
    tick(8);
    load_valid[0] = 1'b0;
    tick(12);
    check("b2b stream", g_lane[0].stream[15:0], 32'hA53C);
    check("b2b nbits", g_lane[0].nbits - b0, 16);
    check("b2b nlast", g_lane[0].nlast - l0, 2);

    // LSB first, 8'h01: a one followed by seven zeros.
    b1 = g_lane[1].nbits;
    parallel_in[1] = 8'h01; load_valid[1] = 1'b1;
    tick(1);
    load_valid[1] = 1'b0;
    tick(12);
    check("lsb stream", g_lane[1].stream[7:0], 32'h80);
    check("lsb nbits", g_lane[1].nbits - b1, 8);

    // 8'hFF, then 8'h00 offered from the second bit on.
    b0 = g_lane[0].nbits;
    parallel_in[0] = 8'hFF; load_valid[0] = 1'b1;
    tick(1);
    parallel_in[0] = 8'h00;
    tick(8);
    load_valid[0] = 1'b0;
    tick(12);
    check("ff00 stream", g_lane[0].stream[15:0], 32'hFF00);
    check("ff00 nbits", g_lane[0].nbits - b0, 16);

    // Reset after the third bit of 8'hFF.
    b0 = g_lane[0].nbits; l0 = g_lane[0].nlast;
    parallel_in[0] = 8'hFF; load_valid[0] = 1'b1;
    tick(1);
    load_valid[0] = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("midrst valid", 32'(serial_valid[0]), 32'(0));
    check("midrst out", 32'(serial_out[0]), 32'(0));
    check("midrst last", 32'(last_bit[0]), 32'(0));
    rst_n = 1'b1;
    #1;
    check("midrst ready", 32'(load_ready[0]), 32'(1));
    tick(12);
    check("midrst nbits", g_lane[0].nbits - b0, 3);
    check("midrst nlast", g_lane[0].nlast - l0, 0);

    // Loopback of 8'hC3 into a serial-in receiver.
    parallel_in[0] = 8'hC3; load_valid[0] = 1'b1;
    tick(1);
    load_valid[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (last_bit[0]) seen = 1'b1;
    end
    check("loop last_seen", 32'(seen), 32'(1));
    @(posedge clk);
    #1;
    check("loop word", 32'(g_lane[0].sipo), 32'hC3);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_register.md
# piso_shift_register

Parallel-in, serial-out shift register with a valid/ready load handshake. It is the transmit-side counterpart of the existing serial-in/parallel-out `shift_register`. It accepts a WIDTH-bit word, then drives it one bit per clock on `serial_out`, qualified by `serial_valid` and a last-bit marker. The next word can be accepted in the last bit cycle of the current word, so consecutive words stream with no idle gap.

## Interface

Parameters:
- WIDTH, 8, word length in bits; must be ≥ 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_valid  in  1  `parallel_in` holds a word to send.
- load_ready  out  1  block can accept a word this cycle (combinational).
- parallel_in  in  WIDTH  word to serialize; sampled only on an accept edge.
- serial_out  out  1  current serial bit (registered).
- serial_valid  out  1  `serial_out` carries a valid data bit (registered).
- last_bit  out  1  high during the final bit of a word (registered).

## Operation

- Accept: a word is accepted on a rising edge where `load_valid && load_ready`. `parallel_in` is copied into the internal shift register and the bit counter is set to WIDTH-1.
- `load_ready` = rst_n && (state == IDLE || (state == SHIFT && count == 0)).
- States:
  - IDLE: no word in flight.
    - On accept: go to SHIFT.
    - Otherwise: stay in IDLE with `serial_valid` = 0, `serial_out` = 0, `last_bit` = 0.
  - SHIFT: while count > 0, each edge shifts the register one position toward the output end and decrements count by 1.
  - At count == 0 in SHIFT:
    - If accept occurs: reload the register and counter, stay in SHIFT. There is no gap cycle.
    - Otherwise: go to IDLE.
- Bit order:
  - MSB_FIRST = 1: `serial_out` = reg[WIDTH-1]; the register shifts left and fills with 0.
  - MSB_FIRST = 0: `serial_out` = reg[0]; the register shifts right and fills with 0.
- `last_bit` = (state == SHIFT && count == 0). It is derived from registered state only.
- Counter width is $clog2(WIDTH). The counter never wraps below 0.
- `parallel_in` and `load_valid` are ignored while `load_ready` = 0. A held `load_valid` is accepted at the first edge where `load_ready` = 1.

## Timing

- Reset: when rst_n is low at a rising edge, the next state is IDLE, the register is cleared, count = 0, and `serial_out`, `serial_valid` and `last_bit` are all 0. `load_ready` is forced to 0 while rst_n is low.
- Reset mid-word: the word in flight is discarded. No partial-word completion and no `last_bit` pulse follow.
- Latency: for an accept at edge N:
  - The first bit appears on `serial_out` with `serial_valid` = 1 in the cycle after edge N.
  - Bit k (k = 0..WIDTH-1 in send order) is present in cycle N+1+k.
  - `last_bit` = 1 in cycle N+WIDTH.
- After the last bit cycle, if no accept occurs at edge N+WIDTH: `serial_valid` = 0 and `serial_out` = 0 from cycle N+WIDTH+1.
- Back-to-back: if an accept occurs at edge N+WIDTH, the first bit of the next word is in cycle N+WIDTH+1. `serial_valid` stays 1 throughout.
- Throughput: one word per WIDTH cycles.

## Test plan

- WIDTH = 8, MSB_FIRST = 1, load 8'hA5 after reset:
  - Expected: `serial_out` = 1,0,1,0,0,1,0,1 over 8 consecutive cycles with `serial_valid` = 1.
  - `last_bit` = 1 only on the 8th bit; `serial_valid` = 0 afterwards.
- Back-to-back, `load_valid` held high with 8'hA5 then 8'h3C:
  - Expected: 16 contiguous valid bits 10100101 00111100.
  - `load_ready` = 1 only in IDLE and in the two last-bit cycles.
  - `last_bit` pulses on cycles 8 and 16.
- MSB_FIRST = 0, load 8'h01:
  - Expected: `serial_out` = 1 then seven 0s.
- Load 8'hFF, assert `load_valid` with 8'h00 from the 2nd bit onward:
  - Expected: the second word is not accepted until the last-bit cycle; the stream is 8 ones then 8 zeros.
  - `parallel_in` changes during the shift do not corrupt the first word.
- Load 8'hFF, drop rst_n for one edge after the 3rd bit:
  - Expected: `serial_valid`, `serial_out` and `last_bit` = 0 on the next cycle; no `last_bit` pulse follows.
  - `load_ready` = 1 once rst_n is high again.
- Loopback, MSB_FIRST = 1: connect `serial_out` to `serial_in` of `shift_register` (WIDTH = 8) and send 8'hC3.
  - Expected: `parallel_out` = 8'hC3 in the cycle after the `last_bit` cycle.
